lsu_mem_ctrl: RTL

Load/store unit front end for the LA32R MEM stage; it is the initiator that drives the data-memory request ports (word read port, word write port). It turns load/store micro-ops into word accesses and extracts/extends sub-word load data. Sub-word stores are handled by read-modify-write, because memory has only a single word write enable and cannot read and write in the same cycle.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_mem_ctrl_lane.sv | 60 ++++++
 rtl/lsu_mem_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit front end.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

  // Micro-op encoding as delivered by the MEM stage.
  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    ST_B  = 3'd5,
    ST_H  = 3'd6,
    ST_W  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    WR     = 2'd2
  } lsu_state_e;

  function automatic logic is_store(mem_op_e op);
    logic r;
    case (op)
      ST_B, ST_H, ST_W: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Bytes are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_aligned(mem_op_e op, logic [1:0] off);
    logic r;
    case (op)
      LD_H, LD_HU, ST_H: r = ~off[0];
      LD_W, ST_W:        r = (off == 2'b00);
      default:           r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: ld_word/ld_off/ld_op -> ld_data (extended load result);
//        st_old/st_new/st_off/st_op -> st_merged (old word with lanes replaced).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  mem_op_e     ld_op,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_new,
  input  logic [1:0]  st_off,
  input  mem_op_e     st_op,
  output logic [31:0] st_merged
);

  logic [31:0] ld_shift;
  logic [31:0] st_mask;
  logic [31:0] st_rep;

  // Bring the addressed lane down to bit 0; aligned halfwords have off[0]=0,
  // so the same shift serves both byte and halfword loads.
  assign ld_shift = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_op)
      LD_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      LD_BU:   ld_data = {24'h0, ld_shift[7:0]};
      LD_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      LD_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  // Replicate the new data across the word and let the mask pick the lane(s).
  always_comb begin
    st_mask = 32'hFFFF_FFFF;
    st_rep  = st_new;
    case (st_op)
      ST_B: begin
        st_mask = 32'h0000_00FF << {st_off, 3'b000};
        st_rep  = {4{st_new[7:0]}};
      end
      ST_H: begin
        st_mask = 32'h0000_FFFF << {st_off[1], 4'b0000};
        st_rep  = {2{st_new[15:0]}};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_rep  = st_new;
      end
    endcase
    st_merged = (st_old & ~st_mask) | (st_rep & st_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU MEM-stage front end: loads, word stores, sub-word stores via read-modify-write.
// Latency: load/ALE 1 cycle, ST_W 2 cycles, ST_B/ST_H 3 cycles (accept edge to resp_valid).
// Backpressure: req_ready low for 1 (ST_W) or 2 (ST_B/ST_H) cycles after a store accept.
// Ports: req_* from MEM stage (valid/ready); resp_* one-cycle completion pulse with
//        load data and alignment exception; rd_* word read port (combinational data);
//        wr_* word write port.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_ale,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  mem_op_e       buf_op_q, buf_op_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_ale_q, resp_ale_d;

  mem_op_e       op;
  logic          accept;
  logic          aligned;
  logic [31:0]   ld_data;
  logic [31:0]   st_merged;

  assign op      = mem_op_e'(req_op);
  assign accept  = req_valid && req_ready;
  assign aligned = is_aligned(op, req_addr[1:0]);

  lsu_lane u_lane (
    .ld_word   (rd_data),
    .ld_off    (req_addr[1:0]),
    .ld_op     (op),
    .ld_data   (ld_data),
    .st_old    (rd_data),
    .st_new    (buf_data_q),
    .st_off    (buf_addr_q[1:0]),
    .st_op     (buf_op_q),
    .st_merged (st_merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only aligned stores leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && aligned && is_store(op)) begin
          state_d = (op == ST_W) ? WR : RMW_RD;
        end
      end
      RMW_RD:  state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. req_ready is gated by rst_n so nothing is accepted in reset;
  // wr_valid decodes state_q, so an async reset drops it at once.
  always_comb begin
    req_ready = 1'b0;
    rd_addr   = req_addr;
    wr_valid  = 1'b0;
    case (state_q)
      IDLE:    req_ready = rst_n;
      RMW_RD:  rd_addr   = buf_addr_q;
      WR:      wr_valid  = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign wr_addr    = buf_addr_q;
  assign wr_data    = buf_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_ale   = resp_ale_q;

  // Store buffer and response datapath.
  always_comb begin
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    buf_op_d     = buf_op_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_ale_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!aligned) begin
            resp_valid_d = 1'b1;
            resp_ale_d   = 1'b1;
          end else if (is_store(op)) begin
            buf_addr_d = req_addr;
            buf_data_d = req_wdata;
            buf_op_d   = op;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
          end
        end
      end
      // Old word is on rd_data this cycle; fold the new lane(s) in.
      RMW_RD:  buf_data_d   = st_merged;
      WR:      resp_valid_d = 1'b1;
      default: resp_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_addr_q   <= '0;
      buf_data_q   <= 32'h0;
      buf_op_q     <= LD_B;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_ale_q   <= 1'b0;
    end else begin
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      buf_op_q     <= buf_op_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_ale_q   <= resp_ale_d;
    end
  end

endmodule
